// File: rtl/sub_pkg.sv
// Shared helpers for the chunked pipelined subtractor: stage count and
// WIDTH/CHUNK legality check.
package sub_pkg;

  function automatic int stage_count(input int width, input int chunk);
    return (chunk > 0) ? width / chunk : 0;
  endfunction

  function automatic bit chunk_legal(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipelined_subtractor_stage.sv
// One CHUNK-bit ripple-borrow slice plus its pipeline registers.
// With PIPELINED_SUBTRACTOR_SAT_EN defined, the last slice clamps the result to 0 on borrow.
module pipelined_subtractor_stage #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int K     = 0
`ifdef PIPELINED_SUBTRACTOR_SAT_EN
  , parameter bit LAST = 1'b0
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_diff,
  input  logic             i_bor,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bor
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic [CHUNK-1:0] slice;
  logic             br;
  logic             ai, bi;

  always_comb begin
    br    = i_bor;
    slice = '0;
    ai    = 1'b0;
    bi    = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      ai       = i_a[K*CHUNK + i];
      bi       = i_b[K*CHUNK + i];
      slice[i] = ai ^ bi ^ br;
      br       = (~ai & bi) | (~(ai ^ bi) & br);
    end

    vld_d  = vld_q;
    a_d    = a_q;
    b_d    = b_q;
    diff_d = diff_q;
    bor_d  = bor_q;
    if (i_load) begin
      vld_d                     = i_vld;
      a_d                       = i_a;
      b_d                       = i_b;
      diff_d                    = i_diff;
      diff_d[K*CHUNK +: CHUNK]  = slice;
      bor_d                     = br;
`ifdef PIPELINED_SUBTRACTOR_SAT_EN
      if (LAST && br) diff_d = '0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      bor_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      diff_q <= diff_d;
      bor_q  <= bor_d;
    end
  end

  assign o_vld  = vld_q;
  assign o_a    = a_q;
  assign o_b    = b_q;
  assign o_diff = diff_q;
  assign o_bor  = bor_q;

endmodule

// File: rtl/pipelined_subtractor.sv
// Valid/ready pipelined subtractor, CHUNK bits resolved per stage, collapsing bubbles.
// Optional unsigned clamp on borrow: define PIPELINED_SUBTRACTOR_SAT_EN.
module pipelined_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int STAGES = stage_count(WIDTH, CHUNK);

  if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("pipelined_subtractor: WIDTH must be a positive multiple of CHUNK");
  end

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] a_pipe, b_pipe, diff_pipe;
  logic [STAGES:0]            bor_pipe;
  logic [STAGES-1:0]          load;

  assign vld_pipe[0]  = i_valid;
  assign a_pipe[0]    = i_a;
  assign b_pipe[0]    = i_b;
  assign diff_pipe[0] = '0;
  assign bor_pipe[0]  = i_bin;

  // A stage advances when empty or when the stage ahead advances this cycle.
  always_comb begin
    load           = '0;
    load[STAGES-1] = !vld_pipe[STAGES] || i_ready;
    for (int k = STAGES - 2; k >= 0; k--) load[k] = !vld_pipe[k+1] || load[k+1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipelined_subtractor_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .K     (k)
`ifdef PIPELINED_SUBTRACTOR_SAT_EN
      , .LAST(bit'(k == STAGES - 1))
`endif
    ) u_stage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (load[k]),
      .i_vld  (vld_pipe[k]),
      .i_a    (a_pipe[k]),
      .i_b    (b_pipe[k]),
      .i_diff (diff_pipe[k]),
      .i_bor  (bor_pipe[k]),
      .o_vld  (vld_pipe[k+1]),
      .o_a    (a_pipe[k+1]),
      .o_b    (b_pipe[k+1]),
      .o_diff (diff_pipe[k+1]),
      .o_bor  (bor_pipe[k+1])
    );
  end

  // Operands carried out of the last stage have no consumer.
  logic unused_ops;
  assign unused_ops = ^{a_pipe[STAGES], b_pipe[STAGES]};

  assign o_ready = load[0];
  assign o_valid = vld_pipe[STAGES];
  assign o_diff  = diff_pipe[STAGES];
  assign o_bout  = bor_pipe[STAGES];

endmodule
